icache_direct: RTL and testbench
================================

// Module: icache_direct
// PURPOSE
//  Direct-mapped, read-only instruction cache between the instruction fetcher (upstream
//  consumer of ins_out) and the memory controller (downstream word-fetch port).
//  Hits return in 1 cycle; misses fill a whole line word-by-word, then answer the fetcher.
//  Flushed requests are dropped, but an in-progress line fill always completes.
// PARAMETERS
//  INDEX_BITS  4  log2(number of lines); 16 lines
//  OFFS_BITS   2  log2(words per line); 4 words = 16 B per line
//  TAG_BITS = 30-INDEX_BITS-OFFS_BITS (derived localparam, not overridable)
// PORTS
//  clk_in      in   1   system clock, all state on posedge
//  rst_in      in   1   synchronous reset, active-high
//  rdy_in      in   1   low: freeze all state; outputs hold
//  fetch_able  in   1   fetcher request valid (may stay high across requests)
//  fetch_pc    in   32  request address, word aligned ([1:0] ignored)
//  br_reset    in   1   flush: cancel the pending fetcher request
//  ins_ready   out  1   one-cycle pulse: ins_out valid for the accepted request
//  ins_out     out  32  instruction word
//  mem_req     out  1   word read request, held high until mem_done
//  mem_addr    out  32  word address of the request; stable while mem_req=1
//  mem_data    in   32  read data, valid when mem_done=1
//  mem_done    in   1   one-cycle completion pulse from the memory controller
// BEHAVIOUR
//  Reset: ins_ready=0, ins_out=0, mem_req=0, mem_addr=0, all valid bits=0, state=IDLE.
//  Address split: tag=pc[31:32-TAG_BITS], index=pc[2+OFFS_BITS+:INDEX_BITS], offs=pc[2+:OFFS_BITS].
//  States: IDLE, FILL, RESP, GAP.
//  IDLE: if fetch_able && !br_reset, latch pc. On hit: ins_out<=word, ins_ready<=1, go GAP
//   (hit latency 1 cycle). On miss: mem_req<=1, mem_addr<={pc[31:2+OFFS_BITS],0..,2'b00},
//   fill counter=0, pend=1, go FILL.
//  FILL: on mem_done: write mem_data to line[index].word[cnt]. If cnt is not the last word:
//   cnt++, mem_addr+=4, mem_req stays 1. If last: valid=1, tag written, mem_req<=0, go RESP.
//  RESP: if pend: ins_out<=latched word, ins_ready<=1; go GAP. If !pend: go IDLE.
//  GAP: ins_ready<=0; ignore fetch_able for this one cycle (fetcher updates fetch_pc); go IDLE.
//  ins_ready is high for exactly one cycle per delivered request, never otherwise.
//  br_reset: any state, clears pend and forces ins_ready<=0 the same edge. In IDLE/RESP/GAP
//   it goes IDLE and accepts no request that edge. In FILL the fill continues to completion
//   (controller cannot abort); the line becomes valid; the dead request gets no response.
//  mem_done outside FILL is ignored. Memory wrap: mem_addr arithmetic is modulo 2^32.
//  rdy_in=0 overrides everything except rst_in; a mem_done arriving while rdy_in=0 is
//   lost (the controller shares rdy_in, so this cannot occur).
//  No write/snoop path: self-modifying code is unsupported.
// CONFIGURATION
//  ICACHE_STATS_EN defined: adds outputs stat_hit[31:0] and stat_miss[31:0]. They are
//   zeroed at reset and count +1 on each IDLE acceptance: hit or miss, flushes included,
//   saturating at 32'hFFFF_FFFF.
//  Not defined: the ports and counters are absent; behaviour is otherwise identical.
// TESTING
//  1 Cold miss: fetch pc=0x100, memory word[i]=0xA000_0000+i ->
//    4 mem_req words at 0x100..0x10C; ins_ready once with ins_out=0xA000_0040.
//  2 Hit: after test 1, fetch pc=0x108 -> ins_ready the next cycle, ins_out=0xA000_0042,
//    mem_req stays 0.
//  3 Conflict: fetch 0x100, then 0x200 (same index, different tag), then 0x100 ->
//    the third access misses and refills; 3 line fills total.
//  4 Flush mid-fill: br_reset during the 2nd mem_done of the 0x300 fill -> the fill
//    completes, no ins_ready; a later fetch at 0x304 hits in 1 cycle.
//  5 Held fetch_able with a changing pc across GAP -> each pc gets exactly one ins_ready;
//    the stale pc is never served.
//  6 rdy_in=0 for 3 cycles during RESP -> ins_ready is delayed 3 cycles, not duplicated;
//    reset mid-FILL -> mem_req=0 and all lines invalid.

Source files
------------

// File: rtl/icache_direct_if.sv
// Fetcher-side and memory-side signals of the direct-mapped instruction cache.
// The cache uses the slave modport; the fetcher/memory environment uses master.
interface icache_direct_if;
    logic        fetch_able;
    logic [31:0] fetch_pc;
    logic        br_reset;
    logic        ins_ready;
    logic [31:0] ins_out;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_done;

    modport slave (
        input  fetch_able, fetch_pc, br_reset, mem_data, mem_done,
        output ins_ready, ins_out, mem_req, mem_addr
    );

    modport master (
        output fetch_able, fetch_pc, br_reset, mem_data, mem_done,
        input  ins_ready, ins_out, mem_req, mem_addr
    );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache; misses fill a whole line word by word.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
//
// state | meaning
// IDLE  | accept a fetch: hit answers next cycle, miss starts a line fill
// FILL  | one word per mem_done until the line is complete
// RESP  | answer the latched request unless it was flushed
// GAP   | one dead cycle so the fetcher can move fetch_pc
module icache_direct #(
    parameter int INDEX_BITS = 4,
    parameter int OFFS_BITS  = 2
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic rdy_in,
    icache_direct_if.slave bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] stat_hit,
    output logic [31:0] stat_miss
`endif
);
    localparam int TAG_BITS = 30 - INDEX_BITS - OFFS_BITS;
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int WORDS    = 1 << OFFS_BITS;

    typedef enum logic [1:0] {IDLE, FILL, RESP, GAP} state_t;
    state_t state, state_nxt;

    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [31:0]         data_mem [LINES*WORDS];
    logic [LINES-1:0]    valid;

    logic [31:2]          pc_q;
    logic [OFFS_BITS-1:0] cnt;
    logic                 pend;

    logic [TAG_BITS-1:0]   req_tag, lat_tag;
    logic [INDEX_BITS-1:0] req_idx, lat_idx;
    logic [OFFS_BITS-1:0]  req_offs, lat_offs;
    logic                  lookup_hit;
    logic                  accept, do_hit, do_miss, fill_wr, fill_last, deliver;
    logic                  unused_pc_bits;

    assign req_tag  = bus.fetch_pc[31 -: TAG_BITS];
    assign req_idx  = bus.fetch_pc[2+OFFS_BITS +: INDEX_BITS];
    assign req_offs = bus.fetch_pc[2 +: OFFS_BITS];
    assign lat_tag  = pc_q[31 -: TAG_BITS];
    assign lat_idx  = pc_q[2+OFFS_BITS +: INDEX_BITS];
    assign lat_offs = pc_q[2 +: OFFS_BITS];
    assign unused_pc_bits = ^bus.fetch_pc[1:0];

    assign lookup_hit = valid[req_idx] && (tag_mem[req_idx] == req_tag);

    always_ff @(posedge clk_in) begin
        if (rst_in)
            state <= IDLE;
        else if (rdy_in)
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.fetch_able && !bus.br_reset)
                      state_nxt = lookup_hit ? GAP : FILL;
            FILL: if (bus.mem_done && (&cnt))
                      state_nxt = RESP;
            RESP: state_nxt = (pend && !bus.br_reset) ? GAP : IDLE;
            GAP:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        accept    = 1'b0;
        do_hit    = 1'b0;
        do_miss   = 1'b0;
        fill_wr   = 1'b0;
        fill_last = 1'b0;
        deliver   = 1'b0;
        case (state)
            IDLE: begin
                accept  = bus.fetch_able && !bus.br_reset;
                do_hit  = accept && lookup_hit;
                do_miss = accept && !lookup_hit;
            end
            FILL: begin
                fill_wr   = bus.mem_done;
                fill_last = bus.mem_done && (&cnt);
            end
            RESP:    deliver = pend && !bus.br_reset;
            default: ;
        endcase
    end

    // A flush during FILL only kills the response; the line still completes.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            bus.ins_ready <= 1'b0;
            bus.ins_out   <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_addr  <= '0;
            valid         <= '0;
            pc_q          <= '0;
            cnt           <= '0;
            pend          <= 1'b0;
        end else if (rdy_in) begin
            bus.ins_ready <= do_hit || deliver;
            if (do_hit)
                bus.ins_out <= data_mem[{req_idx, req_offs}];
            if (deliver)
                bus.ins_out <= data_mem[{lat_idx, lat_offs}];
            if (accept)
                pc_q <= bus.fetch_pc[31:2];
            if (do_miss) begin
                bus.mem_req  <= 1'b1;
                bus.mem_addr <= {bus.fetch_pc[31:2+OFFS_BITS], {(2+OFFS_BITS){1'b0}}};
                cnt          <= '0;
                pend         <= 1'b1;
            end
            if (fill_wr) begin
                if (fill_last) begin
                    valid[lat_idx] <= 1'b1;
                    bus.mem_req    <= 1'b0;
                end else begin
                    cnt          <= cnt + 1'b1;
                    bus.mem_addr <= bus.mem_addr + 32'd4;
                end
            end
            if (bus.br_reset || state == RESP)
                pend <= 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rdy_in && !rst_in && fill_wr) begin
            data_mem[{lat_idx, cnt}] <= bus.mem_data;
            if (fill_last)
                tag_mem[lat_idx] <= lat_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            stat_hit  <= '0;
            stat_miss <= '0;
        end else if (rdy_in) begin
            if (do_hit && stat_hit != 32'hFFFF_FFFF)
                stat_hit <= stat_hit + 32'd1;
            if (do_miss && stat_miss != 32'hFFFF_FFFF)
                stat_miss <= stat_miss + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_icache_direct.sv
// Directed bench for icache_direct: backing memory returns 0xA000_0000 + word address.
// Builds with or without ICACHE_STATS_EN.
module tb_icache_direct;
    localparam int MEM_LAT = 2;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;

    icache_direct_if bus();

`ifdef ICACHE_STATS_EN
    logic [31:0] stat_hit, stat_miss;
`endif

    icache_direct dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus)
`ifdef ICACHE_STATS_EN
        ,
        .stat_hit  (stat_hit),
        .stat_miss (stat_miss)
`endif
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_errors = 0;

    int served   = 0;
    int fills    = 0;
    int resp_cnt = 0;
    logic [31:0] served_q[$];
    logic [31:0] resp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory controller model plus response monitor, sampled 1 time unit after each edge.
    initial begin
        int lat_c;
        lat_c = 0;
        bus.mem_done = 1'b0;
        bus.mem_data = '0;
        forever begin
            @(posedge clk_in);
            #1;
            if (bus.ins_ready) begin
                resp_cnt++;
                resp_q.push_back(bus.ins_out);
            end
            if (bus.mem_done) begin
                bus.mem_done = 1'b0;
            end else if (bus.mem_req) begin
                if (lat_c == MEM_LAT - 1) begin
                    bus.mem_done = 1'b1;
                    bus.mem_data = 32'hA000_0000 + (bus.mem_addr >> 2);
                    served_q.push_back(bus.mem_addr);
                    served++;
                    if (bus.mem_addr[3:2] == 2'b11) fills++;
                    lat_c = 0;
                end else begin
                    lat_c++;
                end
            end else begin
                lat_c = 0;
            end
        end
    end

    task automatic do_fetch(input logic [31:0] pc, input int stall_at,
                            output int lat, output logic [31:0] data);
        lat  = -1;
        data = '0;
        @(negedge clk_in);
        bus.fetch_able = 1'b1;
        bus.fetch_pc   = pc;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk_in);
            if (i == 1) bus.fetch_able = 1'b0;
            if (i == stall_at) rdy_in = 1'b0;
            if (i == stall_at + 3) rdy_in = 1'b1;
            if (bus.ins_ready) begin
                lat  = i;
                data = bus.ins_out;
                break;
            end
        end
        bus.fetch_able = 1'b0;
        rdy_in = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [31:0] d;
        int base_r, base_s, base_f, qb, got;
        bit flushed;

        rst_in = 1'b1;
        rdy_in = 1'b1;
        bus.fetch_able = 1'b0;
        bus.fetch_pc   = '0;
        bus.br_reset   = 1'b0;
        idle_cycles(3);
        rst_in = 1'b0;
        idle_cycles(1);

        check_eq("rst_ins_ready", {31'd0, bus.ins_ready}, 32'd0);
        check_eq("rst_ins_out", bus.ins_out, 32'd0);
        check_eq("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        check_eq("rst_mem_addr", bus.mem_addr, 32'd0);

        // cold miss
        base_r = resp_cnt;
        do_fetch(32'h100, 0, lat, d);
        check_eq("cold_lat", lat, 32'd13);
        check_eq("cold_data", d, 32'hA000_0040);
        idle_cycles(5);
        check_eq("cold_resp_cnt", resp_cnt - base_r, 32'd1);
        check_eq("cold_addr0", served_q[0], 32'h100);
        check_eq("cold_addr1", served_q[1], 32'h104);
        check_eq("cold_addr2", served_q[2], 32'h108);
        check_eq("cold_addr3", served_q[3], 32'h10C);
        check_eq("cold_words", served, 32'd4);

        // hit
        base_s = served;
        do_fetch(32'h108, 0, lat, d);
        check_eq("hit_lat", lat, 32'd1);
        check_eq("hit_data", d, 32'hA000_0042);
        check_eq("hit_no_mem", served - base_s, 32'd0);

        // conflict misses on index 0
        do_fetch(32'h100, 0, lat, d);
        check_eq("conf1_lat", lat, 32'd1);
        check_eq("conf1_data", d, 32'hA000_0040);
        do_fetch(32'h200, 0, lat, d);
        check_eq("conf2_lat", lat, 32'd13);
        check_eq("conf2_data", d, 32'hA000_0080);
        do_fetch(32'h100, 0, lat, d);
        check_eq("conf3_lat", lat, 32'd13);
        check_eq("conf3_data", d, 32'hA000_0040);
        idle_cycles(3);
        check_eq("conf_fills", fills, 32'd3);

        // flush on the 2nd word of the 0x300 fill
        base_r = resp_cnt;
        base_s = served;
        base_f = fills;
        flushed = 1'b0;
        @(negedge clk_in);
        bus.fetch_able = 1'b1;
        bus.fetch_pc   = 32'h300;
        @(negedge clk_in);
        bus.fetch_able = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.mem_done && served == base_s + 2) begin
                bus.br_reset = 1'b1;
                @(negedge clk_in);
                bus.br_reset = 1'b0;
                flushed = 1'b1;
                break;
            end
            @(negedge clk_in);
        end
        check_eq("flush_reached", {31'd0, flushed}, 32'd1);
        idle_cycles(20);
        check_eq("flush_no_resp", resp_cnt - base_r, 32'd0);
        check_eq("flush_fill_done", fills - base_f, 32'd1);
        check_eq("flush_mem_req", {31'd0, bus.mem_req}, 32'd0);
        do_fetch(32'h304, 0, lat, d);
        check_eq("flush_hit_lat", lat, 32'd1);
        check_eq("flush_hit_data", d, 32'hA000_00C1);

        // flush in IDLE blocks acceptance
        idle_cycles(2);
        base_r = resp_cnt;
        base_s = served;
        bus.fetch_able = 1'b1;
        bus.fetch_pc   = 32'h700;
        bus.br_reset   = 1'b1;
        idle_cycles(3);
        bus.fetch_able = 1'b0;
        bus.br_reset   = 1'b0;
        idle_cycles(5);
        check_eq("idleflush_resp", resp_cnt - base_r, 32'd0);
        check_eq("idleflush_mem", served - base_s, 32'd0);

        // held fetch_able, pc changes right after each response
        base_r = resp_cnt;
        qb = resp_q.size();
        got = 0;
        @(negedge clk_in);
        bus.fetch_able = 1'b1;
        bus.fetch_pc   = 32'h304;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_in);
            if (resp_cnt > base_r + got) begin
                got++;
                if (got == 1) bus.fetch_pc = 32'h30C;
                else if (got == 2) bus.fetch_pc = 32'h400;
                else begin
                    bus.fetch_able = 1'b0;
                    break;
                end
            end
        end
        bus.fetch_able = 1'b0;
        idle_cycles(20);
        check_eq("held_resp_cnt", resp_cnt - base_r, 32'd3);
        if (resp_q.size() >= qb + 3) begin
            check_eq("held_data0", resp_q[qb], 32'hA000_00C1);
            check_eq("held_data1", resp_q[qb+1], 32'hA000_00C3);
            check_eq("held_data2", resp_q[qb+2], 32'hA000_0100);
        end

        // rdy_in low for 3 cycles in RESP
        base_r = resp_cnt;
        do_fetch(32'h510, 12, lat, d);
        check_eq("stall_lat", lat, 32'd16);
        check_eq("stall_data", d, 32'hA000_0144);
        idle_cycles(5);
        check_eq("stall_resp_cnt", resp_cnt - base_r, 32'd1);

        // reset in the middle of a fill invalidates everything
        @(negedge clk_in);
        bus.fetch_able = 1'b1;
        bus.fetch_pc   = 32'h600;
        @(negedge clk_in);
        bus.fetch_able = 1'b0;
        idle_cycles(4);
        check_eq("midfill_req", {31'd0, bus.mem_req}, 32'd1);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        check_eq("midrst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        check_eq("midrst_mem_addr", bus.mem_addr, 32'd0);
        check_eq("midrst_ins_out", bus.ins_out, 32'd0);
        idle_cycles(3);
        do_fetch(32'h304, 0, lat, d);
        check_eq("postrst_lat", lat, 32'd13);
        check_eq("postrst_data", d, 32'hA000_00C1);
        do_fetch(32'h108, 0, lat, d);
        check_eq("postrst_miss2_lat", lat, 32'd13);
        check_eq("postrst_miss2_data", d, 32'hA000_0042);

        idle_cycles(3);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
